acc_datapath: RTL

// - Execute stage of the 16-bit accumulator CPU. Sits directly downstream of the memory/control stage.
// - Consumes that stage's decoded control strobes plus IROut/MDROut.
// - Holds the architectural PC, ACC and SP registers and the ALUOut register.
// - Returns PC, ACC and ALUOut to the memory stage for addressing and store data.

---
 rtl/acc_datapath.sv | 133 +++++++++++++
 1 files changed

// File: rtl/acc_datapath.sv
// acc_datapath: execute stage of the 16-bit accumulator CPU.
// Holds PC, ACC, SP and ALUOut; all sequencing comes from the upstream control unit.
// Optional feature macro: ACC_OVF_EN builds a sticky signed-overflow flag on Ovf.
module acc_datapath #(
  parameter logic [15:0] SP_INIT = 16'h07fe,
  parameter logic [15:0] PC_INIT = 16'h0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  PCWrite,
  input  logic [1:0]  BneOrBeq,
  input  logic [2:0]  ACCSrc,
  input  logic        ACCWrite,
  input  logic        SPWrite,
  input  logic [1:0]  ALUSrcA,
  input  logic [2:0]  ALUSrcB,
  input  logic [2:0]  ALUOp,
  input  logic [15:0] IROut,
  input  logic [15:0] MDROut,
  output logic [15:0] PC,
  output logic [15:0] ACC,
  output logic [15:0] SP,
  output logic [15:0] ALUOut,
  output logic        Zero,
  output logic        Ovf
);

  logic [9:0]  imm;
  logic [15:0] imm_sx, imm_zx;
  logic [15:0] alu_a, alu_b, alu_res;
  logic [15:0] pc_next;
  logic        taken, pc_we;
  logic        unused_ir;

  assign imm       = IROut[9:0];
  assign imm_sx    = {{6{imm[9]}}, imm};
  assign imm_zx    = {6'd0, imm};
  // IROut[15:10] is opcode space consumed upstream
  assign unused_ir = &{1'b0, IROut[15:10]};

  // Operand muxes and ALU function
  always_comb begin
    alu_a = 16'h0000;
    case (ALUSrcA)
      2'd0:    alu_a = PC;
      2'd1:    alu_a = ACC;
      2'd2:    alu_a = SP;
      default: alu_a = 16'h0000;
    endcase
    alu_b = 16'h0000;
    case (ALUSrcB)
      3'd0:    alu_b = MDROut;
      3'd1:    alu_b = 16'h0002;
      3'd2:    alu_b = imm_sx;
      3'd3:    alu_b = imm_zx;
      3'd4:    alu_b = {imm_sx[14:0], 1'b0};
      3'd5:    alu_b = {IROut[7:0], 8'h00};
      default: alu_b = 16'h0000;
    endcase
    alu_res = 16'h0000;
    case (ALUOp)
      3'd0:    alu_res = alu_a + alu_b;
      3'd1:    alu_res = alu_a - alu_b;
      3'd2:    alu_res = alu_a & alu_b;
      3'd3:    alu_res = alu_a | alu_b;
      3'd4:    alu_res = ($signed(alu_a) < $signed(alu_b)) ? 16'h0001 : 16'h0000;
      3'd5:    alu_res = alu_b;
      default: alu_res = 16'h0000;
    endcase
  end

  assign Zero = (alu_res == 16'h0000);

  // Branch decision and next-PC select; unconditional write dominates
  always_comb begin
    taken   = ((BneOrBeq == 2'b01) && Zero) || ((BneOrBeq == 2'b10) && !Zero);
    pc_we   = PCWrite[0] || (PCWrite[1] && taken);
    pc_next = alu_res;
    case (PCSrc)
      2'd0:    pc_next = alu_res;
      2'd1:    pc_next = ALUOut;
      2'd2:    pc_next = {PC[15:11], imm, 1'b0};
      default: pc_next = ACC;
    endcase
  end

  // Architectural registers; every write sees pre-edge values, reset wins
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      PC     <= PC_INIT;
      ACC    <= 16'h0000;
      SP     <= SP_INIT;
      ALUOut <= 16'h0000;
    end else begin
      ALUOut <= alu_res;
      if (pc_we)   PC <= pc_next;
      if (SPWrite) SP <= alu_res;
      if (ACCWrite) begin
        case (ACCSrc)
          3'd0:    ACC <= ALUOut;
          3'd1:    ACC <= MDROut;
          3'd2:    ACC <= alu_res;
          3'd3:    ACC <= imm_sx;
          3'd4:    ACC <= PC;
          default: ACC <= ACC;
        endcase
      end
    end
  end

`ifdef ACC_OVF_EN
  logic ovf_now;

  // Signed overflow of add/sub: operand signs vs result sign
  always_comb begin
    ovf_now = 1'b0;
    if (ALUOp == 3'd0)
      ovf_now = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
    else if (ALUOp == 3'd1)
      ovf_now = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
  end

  // Sticky flag, cleared only by reset
  always_ff @(posedge CLK) begin
    if (!Reset)       Ovf <= 1'b0;
    else if (ovf_now) Ovf <= 1'b1;
  end
`else
  assign Ovf = 1'b0;
`endif

endmodule
